// File: rtl/edge_tx_packer.sv
// Edge-map transmit packer: binarizes edge pixels, packs 8 per byte (MSB first), frames as SYNC0,SYNC1,payload[,checksum].
// Latency: SYNC0 offered 2 cycles after pixel 0 when idle; payload bytes stream at 1/cycle with i_tx_ready held high.
// Backpressure: valid/ready byte handshake; the byte FIFO absorbs stalls, bytes arriving on a full FIFO are dropped and flagged.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_de, i_data      : edge pixel stream (valid + value)
//   o_tx_valid/o_tx_byte/i_tx_ready : byte handshake towards the UART transmitter
//   o_frame_sent      : one-cycle pulse after the last byte of a frame is accepted
//   o_overflow        : sticky error (FIFO drop or new frame start while one is still pending)
//   o_busy            : FSM not idle or FIFO not empty
// Optional feature: define EDGE_TX_CHECKSUM_EN to append the XOR of all payload bytes after the payload.

module edge_tx_packer #(
   parameter int         DATA_WIDTH = 8,
   parameter int         IMG_WIDTH  = 176,
   parameter int         IMG_HEIGHT = 240,
   parameter int         FIFO_DEPTH = 5,
   parameter int         BIN_TH     = 128,
   parameter logic [7:0] SYNC0      = 8'hAA,
   parameter logic [7:0] SYNC1      = 8'h55
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_de,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_tx_valid,
   output logic [7:0]            o_tx_byte,
   input  logic                  i_tx_ready,
   output logic                  o_frame_sent,
   output logic                  o_overflow,
   output logic                  o_busy
);

   localparam int TOTAL_PIXELS    = IMG_WIDTH * IMG_HEIGHT;
   localparam int BYTES_PER_FRAME = TOTAL_PIXELS / 8;
   localparam int PIX_W           = $clog2(TOTAL_PIXELS + 1);
   localparam int BYTE_W          = $clog2(BYTES_PER_FRAME + 1);
   localparam int DEPTH           = 1 << FIFO_DEPTH;

   localparam logic [PIX_W-1:0]      PIX_LAST  = PIX_W'(TOTAL_PIXELS - 1);
   localparam logic [BYTE_W-1:0]     BYTE_LAST = BYTE_W'(BYTES_PER_FRAME - 1);
   localparam logic [DATA_WIDTH-1:0] TH        = DATA_WIDTH'(BIN_TH);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR0    = 3'd1,
      S_HDR1    = 3'd2,
      S_PAYLOAD = 3'd3,
`ifdef EDGE_TX_CHECKSUM_EN
      S_TRAIL   = 3'd4,
`endif
      S_DONE    = 3'd5
   } state_t;

   // ------------------------------------------------------------------
   // Pixel side: binarize and pack
   // ------------------------------------------------------------------
   logic [PIX_W-1:0] r_pix_cnt;
   logic [7:0]       r_shift;
   logic             r_pending;
   logic             r_overflow;

   logic       w_bit;
   logic [7:0] w_mask;
   logic [7:0] w_shift_base;
   logic [7:0] w_shift_next;
   logic       w_push;
   logic       w_pix0;
   logic       w_take;

   assign w_bit  = (i_data >= TH);
   assign w_mask = 8'h80 >> r_pix_cnt[2:0];
   // The first bit of each byte starts from a clean byte so no stale bits leak in.
   assign w_shift_base = (r_pix_cnt[2:0] == 3'd0) ? 8'h00 : r_shift;
   assign w_shift_next = w_bit ? (w_shift_base | w_mask) : w_shift_base;
   assign w_push       = i_de & (r_pix_cnt[2:0] == 3'd7);
   assign w_pix0       = i_de & (r_pix_cnt == '0);

   // ------------------------------------------------------------------
   // Byte FIFO (extra pointer bit distinguishes full from empty)
   // ------------------------------------------------------------------
   logic [7:0]          r_mem [DEPTH];
   logic [FIFO_DEPTH:0] r_wr_ptr;
   logic [FIFO_DEPTH:0] r_rd_ptr;

   logic       w_empty;
   logic       w_full;
   logic       w_pop;
   logic       w_wr_ok;
   logic       w_drop;
   logic [7:0] w_head;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[FIFO_DEPTH-1:0] == r_rd_ptr[FIFO_DEPTH-1:0]) &
                    (r_wr_ptr[FIFO_DEPTH] != r_rd_ptr[FIFO_DEPTH]);
   // A pop in the same cycle frees the slot being written, so full+pop still accepts.
   assign w_wr_ok = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;
   assign w_head  = r_mem[r_rd_ptr[FIFO_DEPTH-1:0]];

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr[FIFO_DEPTH-1:0]] <= w_shift_next;
      end
   end

   // ------------------------------------------------------------------
   // Framing FSM; all outputs decode registered state/FIFO flags only,
   // so o_tx_valid never depends on i_tx_ready.
   // ------------------------------------------------------------------
   state_t            r_state;
   state_t            w_state_nxt;
   logic [BYTE_W-1:0] r_byte_cnt;
   logic              w_tx_valid;
   logic [7:0]        w_tx_byte;
   logic              w_frame_sent;
   logic              w_xfer;

`ifdef EDGE_TX_CHECKSUM_EN
   logic [7:0] r_chk;
`endif

   assign w_xfer = w_tx_valid & i_tx_ready;
   assign w_pop  = w_xfer & (r_state == S_PAYLOAD);
   assign w_take = (r_state == S_IDLE) & r_pending;

   always_comb begin
      w_state_nxt  = r_state;
      w_tx_valid   = 1'b0;
      w_tx_byte    = 8'h00;
      w_frame_sent = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pending) w_state_nxt = S_HDR0;
         end
         S_HDR0: begin
            w_tx_valid = 1'b1;
            w_tx_byte  = SYNC0;
            if (i_tx_ready) w_state_nxt = S_HDR1;
         end
         S_HDR1: begin
            w_tx_valid = 1'b1;
            w_tx_byte  = SYNC1;
            if (i_tx_ready) w_state_nxt = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            w_tx_valid = ~w_empty;
            w_tx_byte  = w_empty ? 8'h00 : w_head;
            if (~w_empty & i_tx_ready & (r_byte_cnt == BYTE_LAST)) begin
`ifdef EDGE_TX_CHECKSUM_EN
               w_state_nxt = S_TRAIL;
`else
               w_state_nxt = S_DONE;
`endif
            end
         end
`ifdef EDGE_TX_CHECKSUM_EN
         S_TRAIL: begin
            w_tx_valid = 1'b1;
            w_tx_byte  = r_chk;
            if (i_tx_ready) w_state_nxt = S_DONE;
         end
`endif
         S_DONE: begin
            w_frame_sent = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pix_cnt  <= '0;
         r_shift    <= 8'h00;
         r_pending  <= 1'b0;
         r_overflow <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_byte_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (i_de) begin
            r_shift   <= w_shift_next;
            r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + PIX_W'(1);
         end

         // A pixel 0 arriving while the previous frame start is still unclaimed
         // means the transmitter has fallen a whole frame behind.
         r_pending  <= (r_pending & ~w_take) | w_pix0;
         r_overflow <= r_overflow | w_drop | (w_pix0 & r_pending & ~w_take);

         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + (FIFO_DEPTH + 1)'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + (FIFO_DEPTH + 1)'(1);

         if (r_state != S_PAYLOAD) r_byte_cnt <= '0;
         else if (w_pop)           r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
      end
   end

`ifdef EDGE_TX_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset)       r_chk <= 8'h00;
      else if (w_take) r_chk <= 8'h00;
      else if (w_pop)  r_chk <= r_chk ^ w_head;
   end
`endif

   assign o_tx_valid   = w_tx_valid;
   assign o_tx_byte    = w_tx_byte;
   assign o_frame_sent = w_frame_sent;
   assign o_overflow   = r_overflow;
   assign o_busy       = (r_state != S_IDLE) | ~w_empty;

endmodule
